// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI-lite register bank of NUM_REGS x DATA_WD.
// Define AXIL_SLV_ADDR_CHECK_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave_regs #(
  parameter int DATA_WD  = 8,
  parameter int ADDR_WD  = 8,
  parameter int NUM_REGS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               awvalid,
  input  logic [ADDR_WD-1:0] awaddr,
  output logic               awready,
  input  logic               wvalid,
  input  logic [DATA_WD-1:0] wdata,
  output logic               wready,
  output logic               bvalid,
  output logic [1:0]         brsp,
  input  logic               bready,
  input  logic               arvalid,
  input  logic [ADDR_WD-1:0] araddr,
  output logic               arready,
  output logic               rvalid,
  output logic [DATA_WD-1:0] rdata,
  output logic [1:0]         rrsp,
  input  logic               rready
);

  localparam int IDX_WD = $clog2(NUM_REGS);
  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;

  logic [DATA_WD-1:0] regs_q [NUM_REGS];

  logic               aw_held;
  logic               w_held;
  logic [ADDR_WD-1:0] aw_addr_q;
  logic [DATA_WD-1:0] w_data_q;

  logic               aw_fire;
  logic               w_fire;
  logic               ar_fire;
  logic               wr_go;
  logic [ADDR_WD-1:0] wr_addr;
  logic [DATA_WD-1:0] wr_data;
  logic [IDX_WD-1:0]  wr_idx;
  logic [IDX_WD-1:0]  rd_idx;
  logic               wr_ok;
  logic               rd_ok;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;

  // A write commits once both halves are either held or arriving now.
  assign wr_go   = (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_idx  = wr_addr[IDX_WD-1:0];
  assign rd_idx  = araddr[IDX_WD-1:0];

`ifdef AXIL_SLV_ADDR_CHECK_EN
  // One extra bit so NUM_REGS == 2**ADDR_WD still compares correctly.
  localparam logic [ADDR_WD:0] LIMIT = (ADDR_WD+1)'(NUM_REGS);
  assign wr_ok = {1'b0, wr_addr} < LIMIT;
  assign rd_ok = {1'b0, araddr} < LIMIT;
`else
  logic unused_hi;
  assign unused_hi = ^{wr_addr, araddr};
  assign wr_ok     = 1'b1;
  assign rd_ok     = 1'b1;
`endif

  // Hold AW and W halves until their partner shows up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else if (wr_go) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
      end
    end
  end

  // Register array; out-of-range writes are dropped when checking is on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_go && wr_ok) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Write response: raised on commit, held until bready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bvalid <= 1'b0;
      brsp   <= RSP_OKAY;
    end else if (wr_go) begin
      bvalid <= 1'b1;
      brsp   <= wr_ok ? RSP_OKAY : RSP_SLVERR;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
  end

  // Read data: sampled from the array before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rrsp   <= RSP_OKAY;
    end else if (ar_fire) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? regs_q[rd_idx] : '0;
      rrsp   <= rd_ok ? RSP_OKAY : RSP_SLVERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed and random checks of the register bank
// against an array model of the register contents.
module tb_axi_lite_slave_regs;

`ifdef AXIL_SLV_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       awvalid = 1'b0;
  logic [7:0] awaddr = '0;
  logic       awready;
  logic       wvalid = 1'b0;
  logic [7:0] wdata = '0;
  logic       wready;
  logic       bvalid;
  logic [1:0] brsp;
  logic       bready = 1'b0;
  logic       arvalid = 1'b0;
  logic [7:0] araddr = '0;
  logic       arready;
  logic       rvalid;
  logic [7:0] rdata;
  logic [1:0] rrsp;
  logic       rready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model [16];

  axi_lite_slave_regs dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .brsp(brsp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rrsp(rrsp), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input int a);
    return !CHK_EN || (a < 16);
  endfunction

  function automatic logic [1:0] exp_rsp(input int a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [7:0] exp_rd(input int a);
    return in_range(a) ? model[a % 16] : 8'h00;
  endfunction

  task automatic wr(input int a, input logic [7:0] d, input int aw_dly,
                    input int w_dly, input int b_dly);
    bit aw_done;
    bit w_done;
    int cyc;
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    while (!(aw_done && w_done)) begin
      if (cyc >= 50) begin
        awvalid = 0;
        wvalid  = 0;
        chk("wr_timeout", 0, 1);
        return;
      end
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = 8'(a);
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = d;
      if (aw_done) chk("awready_held", awready, 0);
      if (w_done) chk("wready_held", wready, 0);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      cyc++;
    end
    awvalid = 0;
    wvalid  = 0;
    chk("b_latency", bvalid, 1);
    chk("brsp", brsp, exp_rsp(a));
    if (in_range(a)) model[a % 16] = d;
    repeat (b_dly) begin
      chk("b_stable", {bvalid, brsp}, {1'b1, exp_rsp(a)});
      chk("aw_w_blocked", {awready, wready}, 0);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("b_done", bvalid, 0);
    chk("aw_w_open", {awready, wready}, 2'b11);
  endtask

  task automatic rd(input int a, input int r_dly);
    logic [7:0] e;
    logic [1:0] r;
    e = exp_rd(a);
    r = exp_rsp(a);
    chk("arready", arready, 1);
    arvalid = 1;
    araddr  = 8'(a);
    @(negedge clk);
    arvalid = 0;
    chk("r_latency", rvalid, 1);
    chk("rdata", rdata, e);
    chk("rrsp", rrsp, r);
    repeat (r_dly) begin
      chk("r_stable", {rvalid, rrsp, rdata}, {1'b1, r, e});
      chk("ar_blocked", arready, 0);
      @(negedge clk);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("r_done", rvalid, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {bvalid, rvalid, brsp, rrsp, rdata}, 0);
    chk("readies", {awready, wready, arready}, 3'b111);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] old;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    repeat (2) @(negedge clk);
    rst_n = 1;
    chk_idle("reset_state");

    // Same-cycle AW+W, then read back.
    wr(3, 8'hA5, 0, 0, 0);
    rd(3, 0);

    // AW first, W three cycles later; then W first.
    wr(5, 8'h3C, 0, 3, 0);
    rd(5, 0);
    wr(6, 8'hC3, 3, 0, 0);
    rd(6, 1);

    // Back-pressure on B for five cycles.
    wr(9, 8'h5A, 0, 0, 5);
    rd(9, 3);

    // Read and write of the same index at the same edge.
    old = model[7];
    awvalid = 1; awaddr = 8'd7; wvalid = 1; wdata = 8'h11;
    arvalid = 1; araddr = 8'd7;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("rbw_rvalid", rvalid, 1);
    chk("rbw_bvalid", bvalid, 1);
    chk("rbw_old", rdata, old);
    model[7] = 8'h11;
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    rd(7, 0);

    // Out-of-range / wrapping address.
    wr(8'h13, 8'hFF, 0, 0, 0);
    rd(3, 0);
    rd(8'h13, 0);

    // Reset while AW is held and W is arriving.
    awvalid = 1; awaddr = 8'd2;
    @(negedge clk);
    awvalid = 0;
    rst_n = 0; wvalid = 1; wdata = 8'h77;
    @(negedge clk);
    rst_n = 1; wvalid = 0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk_idle("mid_reset");
    repeat (2) @(negedge clk);
    chk("no_b_after_reset", bvalid, 0);
    for (int i = 0; i < 16; i++) rd(i, 0);
    wr(2, 8'h55, 1, 0, 1);
    rd(2, 0);

    // Random traffic.
    repeat (80) begin
      int a;
      a = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        wr(a, 8'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        rd(a, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
